sobel_grad: RTL and testbench

//  Gradient stage directly upstream of the Canny NMS/hysteresis block: consumes one
//  8-bit greyscale pixel stream (raster order), forms 3x3 Sobel windows, and emits
//  per-pixel magnitude (8b) and direction bin (6b, 0..35, 10-degree bins) aligned to
//  the window centre. Exactly WIDTH*HEIGHT outputs per frame, fed straight to mag/dir inputs.

---
 rtl/sobel_grad_pkg.sv | 23 ++
 rtl/sobel_grad_linebuf.sv | 40 ++++
 rtl/sobel_grad.sv | 206 ++++++++++++++++++++
 tb/tb_sobel_grad.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_grad_pkg.sv
// Shared constants and types for the Sobel gradient stage: direction LUT,
// FSM state encoding and datapath widths.
package sobel_grad_pkg;

  localparam int DATA_W   = 8;
  localparam int GRAD_W   = 11;
  localparam int DIR_BINS = 36;
  localparam int DIR_W    = $clog2(DIR_BINS);

  // round(tan(10*i deg) * 1024) for i = 8..1
  localparam logic [8:1][12:0] TAN_LUT = {
    13'd5807, 13'd2813, 13'd1774, 13'd1220,
    13'd859,  13'd591,  13'd373,  13'd181
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/sobel_grad_linebuf.sv
// Two line buffers feeding a 3x3 shift window; win[0..8] = p1..p9 row-major,
// advancing only when adv is high.
module sobel_grad_linebuf #(
  parameter  int DATA_W = 8,
  parameter  int WIDTH  = 512,
  localparam int CW     = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   adv,
  input  logic [CW-1:0]          col,
  input  logic [DATA_W-1:0]      pix,
  output logic [8:0][DATA_W-1:0] win
);

  logic [DATA_W-1:0] lb1 [WIDTH];
  logic [DATA_W-1:0] lb2 [WIDTH];
  logic [DATA_W-1:0] up1;
  logic [DATA_W-1:0] up2;

  assign up1 = lb1[col];
  assign up2 = lb2[col];

  // window register stage: newest column enters on the right
  always_ff @(posedge clk) begin
    if (adv) begin
      lb1[col] <= pix;
      lb2[col] <= up1;
      win[0]   <= win[1];
      win[1]   <= win[2];
      win[2]   <= up2;
      win[3]   <= win[4];
      win[4]   <= win[5];
      win[5]   <= up1;
      win[6]   <= win[7];
      win[7]   <= win[8];
      win[8]   <= pix;
    end
  end

endmodule

// File: rtl/sobel_grad.sv
// Sobel gradient stage: raster pixel stream in, per-pixel magnitude and
// 10-degree direction bin out, aligned to the window centre.
module sobel_grad
  import sobel_grad_pkg::*;
#(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              din_sof,
  output logic              din_ready,
  output logic [DATA_W-1:0] mag,
  output logic [DIR_W-1:0]  dir,
  output logic              dout_valid,
  output logic              frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT + 2);

  state_t state, state_nxt;
  logic [CW-1:0] col_cnt, cur_col;
  logic [RW-1:0] row_cnt, cur_row;
  logic acc, adv, gen, last, brd;
  logic [DATA_W-1:0] pix;
  logic [8:0][DATA_W-1:0] win_p0;

  logic vld_p0, vld_p1, vld_p2;
  logic brd_p0, brd_p1;
  logic last_p0, last_p1, last_p2;
  logic signed [GRAD_W-1:0] gx_p1, gy_p1;
  logic [DATA_W-1:0] mag_p2;
  logic [DIR_W-1:0]  dir_p2;
  logic [9:0]  ax_c, ay_c;
  logic [10:0] sum_c;

  function automatic logic signed [GRAD_W-1:0] sx(input logic [DATA_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic [9:0] abs10(input logic signed [GRAD_W-1:0] v);
    logic signed [GRAD_W-1:0] a;
    a = (v < 0) ? -v : v;
    return a[9:0];
  endfunction

  // number of tan thresholds the ratio n/d meets or exceeds
  function automatic logic [3:0] tan_bin(input logic [9:0] n, input logic [9:0] d);
    logic [23:0] lhs;
    logic [3:0]  cnt;
    lhs = {4'b0000, n, 10'b0};
    cnt = '0;
    for (int i = 1; i <= 8; i++) begin
      if (lhs >= 24'(d) * 24'(TAN_LUT[i])) cnt = cnt + 4'd1;
    end
    return cnt;
  endfunction

  function automatic logic [DIR_W-1:0] dir_of(input logic signed [GRAD_W-1:0] gx,
                                              input logic signed [GRAD_W-1:0] gy);
    logic [9:0] ax, ay;
    ax = abs10(gx);
    ay = abs10(gy);
    if (gx == 0 && gy == 0)     return '0;
    else if (gx > 0 && gy >= 0) return DIR_W'(tan_bin(ay, ax));
    else if (gx <= 0 && gy > 0) return DIR_W'(9)  + DIR_W'(tan_bin(ax, ay));
    else if (gx < 0 && gy <= 0) return DIR_W'(18) + DIR_W'(tan_bin(ay, ax));
    else                        return DIR_W'(27) + DIR_W'(tan_bin(ax, ay));
  endfunction

  assign din_ready = (state != ST_FLUSH);
  assign acc       = din_valid && din_ready;
  assign cur_col   = (acc && din_sof) ? '0 : col_cnt;
  assign cur_row   = (acc && din_sof) ? '0 : row_cnt;
  assign pix       = (state == ST_FLUSH) ? '0 : din;
  // entering element (r,c) completes the window centred on (r-1,c-1)
  assign brd       = (cur_col < CW'(2)) || (cur_row == RW'(1)) || (cur_row == RW'(HEIGHT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    gen       = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc && din_sof) begin
          adv       = 1'b1;
          state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (acc) begin
          adv = 1'b1;
          if (din_sof) state_nxt = ST_FILL;
          else if (cur_row == RW'(1) && cur_col == '0) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (acc) begin
          adv = 1'b1;
          if (din_sof) state_nxt = ST_FILL;
          else begin
            gen = 1'b1;
            if (cur_row == RW'(HEIGHT - 1) && cur_col == CW'(WIDTH - 1)) state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        adv = 1'b1;
        gen = 1'b1;
        if (cur_row == RW'(HEIGHT + 1) && cur_col == '0) begin
          last      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (state_nxt == ST_IDLE) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (adv) begin
      if (cur_col == CW'(WIDTH - 1)) begin
        col_cnt <= '0;
        row_cnt <= cur_row + RW'(1);
      end else begin
        col_cnt <= cur_col + CW'(1);
        row_cnt <= cur_row;
      end
    end
  end

  sobel_grad_linebuf #(.DATA_W(DATA_W), .WIDTH(WIDTH)) u_linebuf (
    .clk (clk),
    .adv (adv),
    .col (cur_col),
    .pix (pix),
    .win (win_p0)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {vld_p0, vld_p1, vld_p2}    <= '0;
      {brd_p0, brd_p1}            <= '0;
      {last_p0, last_p1, last_p2} <= '0;
    end else begin
      vld_p0  <= gen;
      brd_p0  <= brd;
      last_p0 <= last;
      vld_p1  <= vld_p0;
      brd_p1  <= brd_p0;
      last_p1 <= last_p0;
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  // p0 -> p1: gradient components
  always_ff @(posedge clk) begin
    gx_p1 <= (sx(win_p0[2]) + (sx(win_p0[5]) <<< 1) + sx(win_p0[8]))
           - (sx(win_p0[0]) + (sx(win_p0[3]) <<< 1) + sx(win_p0[6]));
    gy_p1 <= (sx(win_p0[6]) + (sx(win_p0[7]) <<< 1) + sx(win_p0[8]))
           - (sx(win_p0[0]) + (sx(win_p0[1]) <<< 1) + sx(win_p0[2]));
  end

  assign ax_c  = abs10(gx_p1);
  assign ay_c  = abs10(gy_p1);
  assign sum_c = {1'b0, ax_c} + {1'b0, ay_c};

  // p1 -> p2: magnitude and direction bin, forced to zero on the border
  always_ff @(posedge clk) begin
    mag_p2 <= brd_p1 ? '0 : sum_c[10:3];
    dir_p2 <= brd_p1 ? '0 : dir_of(gx_p1, gy_p1);
  end

  // p2 -> output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag        <= '0;
      dir        <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= vld_p2;
      frame_done <= vld_p2 && last_p2;
      if (vld_p2) begin
        mag <= mag_p2;
        dir <= dir_p2;
      end
    end
  end

endmodule

// File: tb/tb_sobel_grad.sv
// Randomised self-checking bench for sobel_grad on a reduced frame size,
// compared against an image-level Sobel reference model.
module tb_sobel_grad;

  localparam int W = 16;
  localparam int H = 10;
  localparam int N = W * H;
  localparam int P = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_sof = 1'b0;
  logic       din_ready;
  logic [7:0] mag;
  logic [5:0] dir;
  logic       dout_valid;
  logic       frame_done;

  sobel_grad #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_sof    (din_sof),
    .din_ready  (din_ready),
    .mag        (mag),
    .dir        (dir),
    .dout_valid (dout_valid),
    .frame_done (frame_done)
  );

  always #(P/2) clk = ~clk;

  typedef struct { int m; int d; bit last; } exp_t;

  int     n_checks = 0;
  int     n_errors = 0;
  int     img [H][W];
  int     tanv [8] = '{181, 373, 591, 859, 1220, 1774, 2813, 5807};
  exp_t   exp_q [$];
  longint ts_q [$];
  int     obs_m [N];
  int     obs_d [N];
  int     oidx = 0;
  int     fd_count = 0;
  int     low_cnt = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int tb_bin(int n, int d);
    int c = 0;
    for (int i = 0; i < 8; i++) if (n * 1024 >= d * tanv[i]) c++;
    return c;
  endfunction

  function automatic int ref_dir(int gx, int gy);
    int ax = (gx < 0) ? -gx : gx;
    int ay = (gy < 0) ? -gy : gy;
    if (gx == 0 && gy == 0) return 0;
    if (gx > 0 && gy >= 0)  return tb_bin(ay, ax);
    if (gx <= 0 && gy > 0)  return 9 + tb_bin(ax, ay);
    if (gx < 0 && gy <= 0)  return 18 + tb_bin(ay, ax);
    return 27 + tb_bin(ax, ay);
  endfunction

  function automatic exp_t ref_out(int y, int x, bit last);
    exp_t e;
    int gx, gy;
    e.last = last;
    if (y == 0 || y == H-1 || x == 0 || x == W-1) begin
      e.m = 0;
      e.d = 0;
    end else begin
      gx = (img[y-1][x+1] + 2*img[y][x+1] + img[y+1][x+1])
         - (img[y-1][x-1] + 2*img[y][x-1] + img[y+1][x-1]);
      gy = (img[y+1][x-1] + 2*img[y+1][x] + img[y+1][x+1])
         - (img[y-1][x-1] + 2*img[y-1][x] + img[y-1][x+1]);
      e.m = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 8;
      e.d = ref_dir(gx, gy);
    end
    return e;
  endfunction

  // 0 flat, 1 vstep, 2 vstep rev, 3 hstep, 4 hstep rev, 5 ramp, 6 random
  task automatic make_img(input int kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          0: img[y][x] = 100;
          1: img[y][x] = (x < W/2) ? 0 : 255;
          2: img[y][x] = (x < W/2) ? 255 : 0;
          3: img[y][x] = (y < H/2) ? 0 : 255;
          4: img[y][x] = (y < H/2) ? 255 : 0;
          5: img[y][x] = x + y;
          default: img[y][x] = int'($urandom_range(255));
        endcase
  endtask

  task automatic send_pix(input int pix, input bit sof, input int gap_pct, output longint t_acc);
    int  guard = 0;
    bit  done = 0;
    bit  rdy;
    t_acc = 0;
    while (!done) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        din_valid = 1'b0;
        @(posedge clk); #1;
      end else begin
        din_valid = 1'b1;
        din       = 8'(pix);
        din_sof   = sof;
        rdy       = din_ready;
        @(posedge clk);
        if (rdy) begin
          done  = 1;
          t_acc = $time;
        end
        #1;
      end
      guard++;
      if (!done && guard > 4*W + 50) begin
        check_val("accept_timeout", 0, 1);
        done = 1;
      end
    end
    din_valid = 1'b0;
    din_sof   = 1'b0;
  endtask

  task automatic send_frame(input int npix, input int gap_pct);
    longint t;
    int nout = (npix == N) ? N : ((npix > W + 1) ? npix - W - 1 : 0);
    for (int c = 0; c < nout; c++) exp_q.push_back(ref_out(c / W, c % W, c == N-1));
    for (int k = 0; k < npix; k++) begin
      send_pix(img[k / W][k % W], k == 0, gap_pct, t);
      if (k >= W + 1) ts_q.push_back(t);
      if (k == N - 1)
        for (int i = 1; i <= W + 1; i++) ts_q.push_back(t + longint'(i * P));
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10*N && exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    check_val("drain_left", exp_q.size(), 0);
  endtask

  task automatic run_frame(input int kind, input int gap_pct);
    make_img(kind);
    oidx     = 0;
    fd_count = 0;
    send_frame(N, gap_pct);
    wait_drain();
    check_val("frame_done_count", fd_count, 1);
  endtask

  // output monitor, sampled mid-cycle
  initial begin
    exp_t   e;
    longint t;
    forever begin
      @(negedge clk);
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          check_val("extra_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("mag", mag, e.m);
          check_val("dir", dir, e.d);
          check_val("frame_done", frame_done, e.last);
          if (ts_q.size() > 0) begin
            t = ts_q.pop_front();
            check_val("latency", ($time - P/2) - t, 3*P);
          end else begin
            check_val("latency_missing", 1, 0);
          end
        end
        if (oidx < N) begin
          obs_m[oidx] = int'(mag);
          obs_d[oidx] = int'(dir);
          oidx++;
        end
        if (frame_done) fd_count++;
      end else if (frame_done) begin
        check_val("frame_done_stray", 1, 0);
      end
      if (!din_ready) low_cnt++;
      else if (low_cnt != 0) begin
        check_val("flush_ready_low", low_cnt, W + 1);
        low_cnt = 0;
      end
    end
  end

  initial begin
    longint t;
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_mag", mag, 0);
    check_val("rst_dir", dir, 0);
    check_val("rst_dout_valid", dout_valid, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_din_ready", din_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 0);
    check_val("flat_mag", obs_m[4*W + 5], 0);
    check_val("flat_dir", obs_d[4*W + 5], 0);

    run_frame(1, 0);
    check_val("vstep_mag", obs_m[2*W + W/2], 127);
    check_val("vstep_dir", obs_d[2*W + W/2], 0);
    run_frame(2, 0);
    check_val("vstep_rev_mag", obs_m[2*W + W/2], 127);
    check_val("vstep_rev_dir", obs_d[2*W + W/2], 18);
    run_frame(3, 0);
    check_val("hstep_mag", obs_m[(H/2)*W + 3], 127);
    check_val("hstep_dir", obs_d[(H/2)*W + 3], 9);
    run_frame(4, 0);
    check_val("hstep_rev_mag", obs_m[(H/2)*W + 3], 127);
    check_val("hstep_rev_dir", obs_d[(H/2)*W + 3], 27);

    run_frame(5, 50);
    check_val("ramp_mag", obs_m[3*W + 3], 2);
    check_val("ramp_dir", obs_d[3*W + 3], 4);
    check_val("ramp_border_mag", obs_m[3], 0);
    check_val("ramp_right_mag", obs_m[4*W + W - 1], 0);

    // stray pixels without sof while idle must be ignored
    for (int i = 0; i < 3; i++) send_pix(int'($urandom_range(255)), 1'b0, 0, t);
    run_frame(6, 50);

    // restart with sof in the middle of a frame
    make_img(6);
    send_frame(5*W + 3, 30);
    make_img(6);
    fd_count = 0;
    send_frame(N, 20);
    wait_drain();
    check_val("sof_restart_done", fd_count, 1);

    // asynchronous reset in the middle of a frame
    make_img(6);
    send_frame(4*W, 0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("mid_rst_mag", mag, 0);
    check_val("mid_rst_dir", dir, 0);
    check_val("mid_rst_dout_valid", dout_valid, 0);
    check_val("mid_rst_din_ready", din_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_frame(6, 0);

    repeat (10) @(posedge clk);
    check_val("exp_queue_empty", exp_q.size(), 0);
    check_val("ts_queue_empty", ts_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
